// File: rtl/card_turn_controller.sv
// One player turn of the memory game: cursor movement, two card flips, a face-up hold,
// then the pair is marked matched or hidden again. Sole writer of the card array during play.
module card_turn_controller #(
    parameter int N_CARDS     = 16,
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         izq,
    input  logic                         der,
    input  logic                         sel,
    input  logic                         timeout,
    input  logic [N_CARDS-1:0][4:0]      arr_in,
    output logic                         wr_en,
    output logic [$clog2(N_CARDS)-1:0]   wr_idx,
    output logic [4:0]                   wr_data,
    output logic [$clog2(N_CARDS)-1:0]   cursor,
    output logic [1:0]                   cartas_sel,
    output logic                         se_eligio,
    output logic                         match,
    output logic                         turn_done,
    output logic                         reset_timer
);

    localparam int IDX_W = $clog2(N_CARDS);
    localparam int CNT_W = $clog2(SHOW_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CARDS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHOW_CYCLES - 1);

    localparam logic [1:0] ST_HIDDEN  = 2'b00;
    localparam logic [1:0] ST_SHOWN   = 2'b01;
    localparam logic [1:0] ST_MATCHED = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_FIRST, S_WAIT_SECOND, S_SHOW, S_RES1, S_RES2, S_HIDE1, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cursor_q, cursor_d;
    logic [1:0]         cartas_sel_q, cartas_sel_d;
    logic [IDX_W-1:0]   idx1_q, idx1_d, idx2_q, idx2_d;
    logic [2:0]         sym1_q, sym1_d, sym2_q, sym2_d;
    logic               matched_q, matched_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         btn_q, btn_d;
    logic               wr_en_q, wr_en_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [4:0]         wr_data_q, wr_data_d;
    logic               se_eligio_q, se_eligio_d;
    logic               match_q, match_d;
    logic               turn_done_q, turn_done_d;
    logic               reset_timer_q, reset_timer_d;

    logic               izq_edge, der_edge, sel_edge, move_ok, cur_hidden, pair_eq;
    logic [2:0]         cur_sym;
    logic [IDX_W-1:0]   cursor_step;

    always_comb begin
        btn_d      = {izq, der, sel};
        izq_edge   = izq & ~btn_q[2];
        der_edge   = der & ~btn_q[1];
        sel_edge   = sel & ~btn_q[0];
        // A select press claims the cycle; opposing presses cancel each other.
        move_ok    = !sel_edge && (izq_edge ^ der_edge);
        cur_hidden = (arr_in[cursor_q][4:3] == ST_HIDDEN);
        cur_sym    = arr_in[cursor_q][2:0];
        pair_eq    = (sym1_q == sym2_q);
        if (der_edge) cursor_step = (cursor_q == LAST_IDX) ? '0 : cursor_q + 1'b1;
        else          cursor_step = (cursor_q == '0) ? LAST_IDX : cursor_q - 1'b1;

        // NOTE: every target gets a default here, so no path through the case can infer a latch.
        state_d       = state_q;
        cursor_d      = cursor_q;
        cartas_sel_d  = cartas_sel_q;
        idx1_d        = idx1_q;
        idx2_d        = idx2_q;
        sym1_d        = sym1_q;
        sym2_d        = sym2_q;
        matched_d     = matched_q;
        cnt_d         = cnt_q;
        wr_idx_d      = wr_idx_q;
        wr_data_d     = wr_data_q;
        wr_en_d       = 1'b0;
        se_eligio_d   = 1'b0;
        match_d       = 1'b0;
        turn_done_d   = 1'b0;
        reset_timer_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d       = S_WAIT_FIRST;
                    reset_timer_d = 1'b1;
                    cartas_sel_d  = 2'd0;
                    matched_d     = 1'b0;
                end
            end
            S_WAIT_FIRST: begin
                if (timeout) begin
                    state_d = S_DONE;
                end else if (sel_edge && cur_hidden) begin
                    wr_en_d      = 1'b1;
                    wr_idx_d     = cursor_q;
                    wr_data_d    = {ST_SHOWN, cur_sym};
                    idx1_d       = cursor_q;
                    sym1_d       = cur_sym;
                    cartas_sel_d = 2'd1;
                    se_eligio_d  = 1'b1;
                    state_d      = S_WAIT_SECOND;
                end else if (move_ok) begin
                    cursor_d = cursor_step;
                end
            end
            S_WAIT_SECOND: begin
                // idx1 is compared explicitly: arr_in may not yet show the first flip.
                if (timeout) begin
                    state_d = S_HIDE1;
                end else if (sel_edge && cur_hidden && (cursor_q != idx1_q)) begin
                    wr_en_d      = 1'b1;
                    wr_idx_d     = cursor_q;
                    wr_data_d    = {ST_SHOWN, cur_sym};
                    idx2_d       = cursor_q;
                    sym2_d       = cur_sym;
                    cartas_sel_d = 2'd2;
                    se_eligio_d  = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_SHOW;
                end else if (move_ok) begin
                    cursor_d = cursor_step;
                end
            end
            S_SHOW: begin
                if (cnt_q == CNT_LAST) state_d = S_RES1;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            S_RES1: begin
                wr_en_d   = 1'b1;
                wr_idx_d  = idx1_q;
                wr_data_d = {pair_eq ? ST_MATCHED : ST_HIDDEN, sym1_q};
                matched_d = pair_eq;
                state_d   = S_RES2;
            end
            S_RES2: begin
                wr_en_d   = 1'b1;
                wr_idx_d  = idx2_q;
                wr_data_d = {pair_eq ? ST_MATCHED : ST_HIDDEN, sym2_q};
                state_d   = S_DONE;
            end
            S_HIDE1: begin
                wr_en_d   = 1'b1;
                wr_idx_d  = idx1_q;
                wr_data_d = {ST_HIDDEN, sym1_q};
                state_d   = S_DONE;
            end
            S_DONE: begin
                turn_done_d   = 1'b1;
                match_d       = matched_q;
                matched_d     = 1'b0;
                cartas_sel_d  = 2'd0;
                reset_timer_d = 1'b1;
                state_d       = S_WAIT_FIRST;
            end
            default: state_d = S_IDLE;
        endcase

        // Leaving game-play abandons the turn, including any write about to issue.
        if (!enable) begin
            state_d       = S_IDLE;
            cartas_sel_d  = 2'd0;
            matched_d     = 1'b0;
            wr_en_d       = 1'b0;
            se_eligio_d   = 1'b0;
            match_d       = 1'b0;
            turn_done_d   = 1'b0;
            reset_timer_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cursor_q      <= '0;
            cartas_sel_q  <= 2'd0;
            idx1_q        <= '0;
            idx2_q        <= '0;
            sym1_q        <= 3'd0;
            sym2_q        <= 3'd0;
            matched_q     <= 1'b0;
            cnt_q         <= '0;
            btn_q         <= 3'b000;
            wr_en_q       <= 1'b0;
            wr_idx_q      <= '0;
            wr_data_q     <= 5'd0;
            se_eligio_q   <= 1'b0;
            match_q       <= 1'b0;
            turn_done_q   <= 1'b0;
            reset_timer_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            cartas_sel_q  <= cartas_sel_d;
            idx1_q        <= idx1_d;
            idx2_q        <= idx2_d;
            sym1_q        <= sym1_d;
            sym2_q        <= sym2_d;
            matched_q     <= matched_d;
            cnt_q         <= cnt_d;
            btn_q         <= btn_d;
            wr_en_q       <= wr_en_d;
            wr_idx_q      <= wr_idx_d;
            wr_data_q     <= wr_data_d;
            se_eligio_q   <= se_eligio_d;
            match_q       <= match_d;
            turn_done_q   <= turn_done_d;
            reset_timer_q <= reset_timer_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_idx      = wr_idx_q;
    assign wr_data     = wr_data_q;
    assign cursor      = cursor_q;
    assign cartas_sel  = cartas_sel_q;
    assign se_eligio   = se_eligio_q;
    assign match       = match_q;
    assign turn_done   = turn_done_q;
    assign reset_timer = reset_timer_q;

endmodule

// File: tb/tb_card_turn_controller.sv
// Directed bench for card_turn_controller: stimulus pushes expected events into a queue,
// a negedge monitor pops and compares each write, turn end and timer restart.
module tb_card_turn_controller;

    localparam int SHOW = 4;

    logic            clk = 1'b0;
    logic            rst, enable, izq, der, sel, timeout;
    logic [15:0][4:0] arr;
    logic            wr_en, se_eligio, match, turn_done, reset_timer;
    logic [3:0]      wr_idx, cursor;
    logic [4:0]      wr_data;
    logic [1:0]      cartas_sel;

    typedef enum int {EV_WR, EV_DONE, EV_RT} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       idx;
        int       data;
        int       flag;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  done_cyc = 0;
    int  sel_cyc;

    localparam int B_IZQ = 0, B_DER = 1, B_SEL = 2, B_BOTH = 3;

    card_turn_controller #(.N_CARDS(16), .SHOW_CYCLES(SHOW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .izq(izq), .der(der), .sel(sel),
        .timeout(timeout), .arr_in(arr), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .cursor(cursor), .cartas_sel(cartas_sel),
        .se_eligio(se_eligio), .match(match), .turn_done(turn_done),
        .reset_timer(reset_timer)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for save_cards: registers each write into the card array.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) arr[i] <= {2'b00, 3'(i)};
            arr[0] <= 5'b00_001;
            arr[1] <= 5'b00_101;
            arr[2] <= 5'b00_011;
            arr[9] <= 5'b00_011;
        end else if (wr_en) begin
            arr[wr_idx] <= wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic take(input ev_kind_t k, input int idx, input int data, input int flag);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event kind=%0d idx=%0d data=%0d flag=%0d required=none",
                     k, idx, data, flag);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", k, e.kind);
            if (e.kind == EV_WR && k == EV_WR) begin
                check("ev_wr_idx", idx, e.idx);
                check("ev_wr_data", data, e.data);
                check("ev_se_eligio", flag, e.flag);
            end else if (e.kind == EV_DONE && k == EV_DONE) begin
                check("ev_match", flag, e.flag);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (wr_en) take(EV_WR, int'(wr_idx), int'(wr_data), int'(se_eligio));
            else if (se_eligio) check("se_eligio_without_write", se_eligio, 0);
            if (turn_done) begin
                done_cyc = cyc;
                take(EV_DONE, 0, 0, int'(match));
                check("done_reset_timer", reset_timer, 1);
            end else if (reset_timer) begin
                take(EV_RT, 0, 0, 0);
            end
            if (match && !turn_done) check("match_without_done", match, 0);
        end
    end

    task automatic push_wr(input int idx, input int data, input int sel_flag);
        exp_q.push_back('{EV_WR, idx, data, sel_flag});
    endtask

    task automatic push_done(input int m);
        exp_q.push_back('{EV_DONE, 0, 0, m});
    endtask

    task automatic push_rt();
        exp_q.push_back('{EV_RT, 0, 0, 0});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int b);
        izq = (b == B_IZQ) || (b == B_BOTH);
        der = (b == B_DER) || (b == B_BOTH);
        sel = (b == B_SEL);
        tick(1);
        izq = 1'b0;
        der = 1'b0;
        sel = 1'b0;
        tick(1);
    endtask

    task automatic pulse_timeout();
        timeout = 1'b1;
        tick(1);
        timeout = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; izq = 1'b0; der = 1'b0; sel = 1'b0; timeout = 1'b0;
        tick(2);
        check("reset_cursor", cursor, 0);
        check("reset_wr_en", wr_en, 0);
        check("reset_cartas_sel", cartas_sel, 0);
        check("reset_turn_done", turn_done, 0);
        rst = 1'b0;
        tick(1);
        push_rt();
        enable = 1'b1;
        tick(2);
        check("start_cursor", cursor, 0);

        // Cursor wrap, hold, and opposing presses
        press(B_IZQ);
        check("wrap_izq", cursor, 15);
        press(B_DER);
        check("wrap_der", cursor, 0);
        der = 1'b1;
        tick(100);
        der = 1'b0;
        tick(1);
        check("held_der_single_step", cursor, 1);
        press(B_BOTH);
        check("both_no_move", cursor, 1);
        press(B_DER);
        check("cursor_at_2", cursor, 2);

        // Matching pair at 2 and 9
        push_wr(2, 5'b01_011, 1);
        press(B_SEL);
        check("t3_cartas_one", cartas_sel, 1);
        repeat (7) press(B_DER);
        check("cursor_at_9", cursor, 9);
        push_wr(9, 5'b01_011, 1);
        push_wr(2, 5'b10_011, 0);
        push_wr(9, 5'b10_011, 0);
        push_done(1);
        sel_cyc = cyc;
        press(B_SEL);
        check("t3_cartas_two", cartas_sel, 2);
        tick(12);
        check("t3_latency", done_cyc - sel_cyc, 1 + SHOW + 2 + 1);
        check("t3_cartas_cleared", cartas_sel, 0);

        // Mismatching pair at 0 and 1
        repeat (7) press(B_DER);
        check("cursor_wrap_to_0", cursor, 0);
        push_wr(0, 5'b01_001, 1);
        press(B_SEL);
        press(B_DER);
        push_wr(1, 5'b01_101, 1);
        push_wr(0, 5'b00_001, 0);
        push_wr(1, 5'b00_101, 0);
        push_done(0);
        press(B_SEL);
        tick(12);

        // Illegal selections: same card twice, then an already matched card
        press(B_DER);
        press(B_DER);
        push_wr(3, 5'b01_011, 1);
        press(B_SEL);
        press(B_SEL);
        tick(2);
        check("t5_same_card_cartas", cartas_sel, 1);
        press(B_IZQ);
        press(B_SEL);
        tick(2);
        check("t5_matched_card_cartas", cartas_sel, 1);
        push_wr(3, 5'b00_011, 0);
        push_done(0);
        pulse_timeout();
        tick(4);

        // Timeout after first card at 4, then timeout with no card flipped
        press(B_DER);
        press(B_DER);
        check("cursor_at_4", cursor, 4);
        push_wr(4, 5'b01_100, 1);
        press(B_SEL);
        push_wr(4, 5'b00_100, 0);
        push_done(0);
        pulse_timeout();
        tick(4);
        check("t6_cartas_cleared", cartas_sel, 0);
        push_done(0);
        pulse_timeout();
        tick(4);

        // enable drops during SHOW: turn abandoned, no resolve writes
        press(B_DER);
        push_wr(5, 5'b01_101, 1);
        press(B_SEL);
        press(B_DER);
        push_wr(6, 5'b01_110, 1);
        press(B_SEL);
        pulse_timeout();
        enable = 1'b0;
        tick(1);
        check("drop_cartas_cleared", cartas_sel, 0);
        tick(10);
        check("drop_no_write", wr_en, 0);
        push_rt();
        enable = 1'b1;
        tick(3);
        check("restart_cartas", cartas_sel, 0);

        tick(5);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
